ip_match_ctrl: RTL and testbench
================================

IP_MATCH_CTRL -- requirements
Module: ip_match_ctrl

Interface
REQ-001 SHALL have parameter NUM_IP, default 4, number of comparator lanes sequenced (2..8).
REQ-002 SHALL have parameter DRAIN_CYCLES, default 3, post-packet flush cycles before match sampling.
REQ-003 SHALL have ports, clock and reset first:
- clk  in  1  single clock; all logic on posedge.
- n_rst  in  1  reset, synchronous, active-low.
- cfg_wr_en  in  1  target-IP write strobe.
- cfg_sel  in  $clog2(NUM_IP)  lane index to write.
- cfg_ip  in  32  target IP value.
- cfg_en  in  1  lane enable written with cfg_ip.
- cfg_err  out  1  one-cycle pulse on a dropped write.
- pkt_start  in  1  packet header pulse; carries no data.
- pkt_valid  in  1  data word qualifier.
- pkt_data  in  32  packet word.
- pkt_end  in  1  marks last word; valid only with pkt_valid.
- pkt_ready  out  1  controller accepts start/words.
- cmp_clear  out  1  clear to all comparator lanes.
- cmp_ip  out  32*NUM_IP  per-lane target IP, lane i at [32i+31:32i].
- cmp_data  out  32  registered word stream to all lanes.
- cmp_match  in  NUM_IP  sticky per-lane match flags.
- res_valid  out  1  result available.
- res_ready  in  1  result consumed.
- res_hit  out  1  any enabled lane matched.
- res_idx  out  $clog2(NUM_IP)  lowest matching enabled lane.
- res_mask  out  NUM_IP  enabled-and-matched lanes.
- res_err  out  1  packet aborted by protocol error.
- busy  out  1  state is not IDLE.

Function
REQ-004 SHALL implement FSM IDLE, CLEAR, STREAM, DRAIN, REPORT.
REQ-005 IDLE: pkt_ready=1; pkt_start -> CLEAR; pkt_valid ignored.
REQ-006 CLEAR: exactly one cycle, cmp_clear=1, pkt_ready=0, then STREAM.
REQ-007 STREAM: pkt_ready=1; each pkt_valid word registered onto cmp_data next cycle; pkt_valid&pkt_end -> DRAIN.
REQ-008 STREAM: pkt_valid SHALL be continuous; a cycle without pkt_valid -> DRAIN with error flag set (bubble corrupts comparator byte adjacency).
REQ-009 STREAM: pkt_start -> abort, CLEAR again, no result produced.
REQ-010 DRAIN: cmp_data=0, pkt_ready=0, exactly DRAIN_CYCLES cycles; cmp_match sampled in final DRAIN cycle, then REPORT.
REQ-011 REPORT: res_valid=1, outputs stable until res_valid&res_ready, then IDLE; pkt_ready=0.
REQ-012 res_mask = sampled cmp_match AND lane enables; res_hit = |res_mask; res_idx = lowest set bit, 0 if none.
REQ-013 On error, res_err=1 and res_mask/res_hit/res_idx forced 0.
REQ-014 cfg writes SHALL be accepted only in IDLE (cmp_ip updates next cycle); otherwise dropped and cfg_err pulses one cycle.
REQ-015 Disabled lanes SHALL still drive their stored cmp_ip; only masked in results.
REQ-016 Single-word packet (pkt_valid&pkt_end on first STREAM cycle) SHALL be legal.
REQ-017 Packet length unbounded; no internal word counter wrap affects results.

Reset
REQ-018 n_rst low at posedge -> IDLE, all outputs 0, all cmp_ip 0, all enables 0, error flag 0, mid-packet or mid-REPORT alike.

Configuration
REQ-019 IP_MATCH_COUNT_EN defined: per-lane 16-bit hit counters, +1 per reported non-error packet with lane in res_mask, saturate at 16'hFFFF, cleared on write to that lane or reset; added ports cnt_sel in $clog2(NUM_IP), cnt_val out 16 (combinational read).
REQ-020 IP_MATCH_COUNT_EN undefined: counters and cnt_sel/cnt_val absent; all else identical.

Structure
REQ-021 Package ip_sniff_pkg SHALL hold FSM state enum, default DRAIN_CYCLES, counter width, IP width constant.
REQ-022 Sub-module ip_match_prio_enc (NUM_IP-bit lowest-set-bit encoder) SHALL produce res_idx.

Verification
REQ-023 Bench SHALL cover:
- Lane0=C0A80001 en; start, words 00C0A800,01xxxxxx, end -> res_hit=1, res_idx=0, res_mask=0001.
- Lanes1,2 both matching enabled -> res_idx=1, res_mask=0110; res_ready low 5 cycles -> outputs held.
- Lane match but cfg_en=0 -> res_hit=0, res_mask=0.
- Bubble after 2 words -> res_err=1, res_hit=0; pkt_start mid-STREAM -> cmp_clear pulse, no res_valid.
- cfg_wr_en in STREAM -> cfg_err pulse, cmp_ip unchanged; n_rst low in DRAIN -> IDLE, outputs 0 next cycle.
- With IP_MATCH_COUNT_EN: 3 hit packets lane3 -> cnt_val=3; counter preloaded near saturation stays FFFF.

Source files
------------

// File: rtl/ip_sniff_pkg.sv
// Shared types and constants for the IP match controller.
package ip_sniff_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StStream,
    StDrain,
    StReport
  } state_e;

  localparam int unsigned DefDrainCycles = 3;
  localparam int unsigned CntWidth       = 16;
  localparam int unsigned IpWidth        = 32;

endpackage

// File: rtl/ip_match_ctrl_if.sv
// Packet stream and result handshake bundle between a packet source/sink and the controller.
interface ip_match_ctrl_if
  import ip_sniff_pkg::*;
#(
  parameter int unsigned NUM_IP = 4
);
  logic                      pkt_start;
  logic                      pkt_valid;
  logic [IpWidth-1:0]        pkt_data;
  logic                      pkt_end;
  logic                      pkt_ready;
  logic                      res_valid;
  logic                      res_ready;
  logic                      res_hit;
  logic [$clog2(NUM_IP)-1:0] res_idx;
  logic [NUM_IP-1:0]         res_mask;
  logic                      res_err;

  modport master (
    output pkt_start, pkt_valid, pkt_data, pkt_end, res_ready,
    input  pkt_ready, res_valid, res_hit, res_idx, res_mask, res_err
  );

  modport slave (
    input  pkt_start, pkt_valid, pkt_data, pkt_end, res_ready,
    output pkt_ready, res_valid, res_hit, res_idx, res_mask, res_err
  );
endinterface

// File: rtl/ip_match_prio_enc.sv
// Lowest-set-bit encoder; returns 0 when no bit is set.
module ip_match_prio_enc #(
  parameter int unsigned NUM_IP = 4
) (
  input  logic [NUM_IP-1:0]         req,
  output logic [$clog2(NUM_IP)-1:0] idx
);
  localparam int unsigned SelW = $clog2(NUM_IP);

  always_comb begin
    idx = '0;
    for (int i = NUM_IP - 1; i >= 0; i--) begin
      if (req[i]) idx = SelW'(i);
    end
  end
endmodule

// File: rtl/ip_match_ctrl.sv
// Sequences packet words to NUM_IP comparator lanes and reports the lowest matching lane.
// Optional per-lane hit counters are built when IP_MATCH_COUNT_EN is defined.
module ip_match_ctrl
  import ip_sniff_pkg::*;
#(
  parameter int unsigned NUM_IP       = 4,
  parameter int unsigned DRAIN_CYCLES = DefDrainCycles
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic                      cfg_wr_en,
  input  logic [$clog2(NUM_IP)-1:0] cfg_sel,
  input  logic [IpWidth-1:0]        cfg_ip,
  input  logic                      cfg_en,
  output logic                      cfg_err,
  output logic                      cmp_clear,
  output logic [IpWidth*NUM_IP-1:0] cmp_ip,
  output logic [IpWidth-1:0]        cmp_data,
  input  logic [NUM_IP-1:0]         cmp_match,
`ifdef IP_MATCH_COUNT_EN
  input  logic [$clog2(NUM_IP)-1:0] cnt_sel,
  output logic [CntWidth-1:0]       cnt_val,
`endif
  output logic                      busy,
  ip_match_ctrl_if.slave            bus
);
  localparam int unsigned SelW   = $clog2(NUM_IP);
  localparam int unsigned DrainW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_e              state_q, state_d;
  logic [IpWidth-1:0]  ip_q [NUM_IP];
  logic [NUM_IP-1:0]   en_q;
  logic                err_q;
  logic [DrainW-1:0]   drain_cnt_q;
  logic                cfg_err_q;
  logic                pkt_ready_q;
  logic                cmp_clear_q;
  logic                busy_q;
  logic [IpWidth-1:0]  cmp_data_q;
  logic                res_valid_q;
  logic                res_hit_q;
  logic                res_err_q;
  logic [SelW-1:0]     res_idx_q;
  logic [NUM_IP-1:0]   res_mask_q;

  logic                cfg_ok;
  logic                accept_word;
  logic                bubble;
  logic                drain_last;
  logic                res_fire;
  logic [NUM_IP-1:0]   masked;
  logic [SelW-1:0]     enc_idx;

  assign cfg_ok      = cfg_wr_en && (state_q == StIdle) && (32'(cfg_sel) < NUM_IP);
  assign accept_word = (state_q == StStream) && bus.pkt_valid && !bus.pkt_start;
  // A gap inside the stream breaks byte adjacency across words at the comparators.
  assign bubble      = (state_q == StStream) && !bus.pkt_valid && !bus.pkt_start;
  assign drain_last  = (state_q == StDrain) && (drain_cnt_q == DrainW'(DRAIN_CYCLES - 1));
  assign res_fire    = res_valid_q && bus.res_ready;
  assign masked      = err_q ? '0 : (cmp_match & en_q);

  ip_match_prio_enc #(
    .NUM_IP (NUM_IP)
  ) u_prio_enc (
    .req (masked),
    .idx (enc_idx)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (bus.pkt_start && pkt_ready_q) state_d = StClear;
      StClear:  state_d = StStream;
      StStream: begin
        if (bus.pkt_start)                      state_d = StClear;
        else if (!bus.pkt_valid || bus.pkt_end) state_d = StDrain;
      end
      StDrain:  if (drain_last) state_d = StReport;
      StReport: if (res_fire) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q     <= StIdle;
      for (int i = 0; i < NUM_IP; i++) ip_q[i] <= '0;
      en_q        <= '0;
      err_q       <= 1'b0;
      drain_cnt_q <= '0;
      cfg_err_q   <= 1'b0;
      pkt_ready_q <= 1'b0;
      cmp_clear_q <= 1'b0;
      busy_q      <= 1'b0;
      cmp_data_q  <= '0;
      res_valid_q <= 1'b0;
      res_hit_q   <= 1'b0;
      res_err_q   <= 1'b0;
      res_idx_q   <= '0;
      res_mask_q  <= '0;
    end else begin
      state_q     <= state_d;
      pkt_ready_q <= (state_d == StIdle) || (state_d == StStream);
      cmp_clear_q <= (state_d == StClear);
      busy_q      <= (state_d != StIdle);
      res_valid_q <= (state_d == StReport);
      cfg_err_q   <= cfg_wr_en && !cfg_ok;
      if (cfg_ok) begin
        ip_q[cfg_sel] <= cfg_ip;
        en_q[cfg_sel] <= cfg_en;
      end
      // The last word still lands on cmp_data in the first drain cycle; zeros follow.
      cmp_data_q <= accept_word ? bus.pkt_data : '0;
      if (state_d == StClear) err_q <= 1'b0;
      else if (bubble)        err_q <= 1'b1;
      drain_cnt_q <= (state_q == StDrain) ? drain_cnt_q + 1'b1 : '0;
      if (drain_last) begin
        res_mask_q <= masked;
        res_hit_q  <= |masked;
        res_idx_q  <= enc_idx;
        res_err_q  <= err_q;
      end else if (res_fire) begin
        res_mask_q <= '0;
        res_hit_q  <= 1'b0;
        res_idx_q  <= '0;
        res_err_q  <= 1'b0;
      end
    end
  end

  always_comb begin
    cmp_ip = '0;
    for (int i = 0; i < NUM_IP; i++) cmp_ip[i*IpWidth +: IpWidth] = ip_q[i];
  end

`ifdef IP_MATCH_COUNT_EN
  logic [CntWidth-1:0] hit_cnt_q [NUM_IP];

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      for (int i = 0; i < NUM_IP; i++) hit_cnt_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_IP; i++) begin
        if (cfg_ok && (32'(cfg_sel) == i)) begin
          hit_cnt_q[i] <= '0;
        end else if (res_fire && !res_err_q && res_mask_q[i] && (hit_cnt_q[i] != '1)) begin
          hit_cnt_q[i] <= hit_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign cnt_val = hit_cnt_q[cnt_sel];
`endif

  assign cfg_err       = cfg_err_q;
  assign cmp_clear     = cmp_clear_q;
  assign cmp_data      = cmp_data_q;
  assign busy          = busy_q;
  assign bus.pkt_ready = pkt_ready_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_hit   = res_hit_q;
  assign bus.res_idx   = res_idx_q;
  assign bus.res_mask  = res_mask_q;
  assign bus.res_err   = res_err_q;
endmodule

// File: tb/tb_ip_match_ctrl.sv
// Directed bench for ip_match_ctrl with a behavioural sticky byte-stream comparator per lane.
module tb_ip_match_ctrl;
  localparam int unsigned NumIp = 4;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         cfg_wr_en;
  logic [1:0]   cfg_sel;
  logic [31:0]  cfg_ip;
  logic         cfg_en;
  logic         cfg_err;
  logic         cmp_clear;
  logic [127:0] cmp_ip;
  logic [31:0]  cmp_data;
  logic [3:0]   cmp_match;
  logic         busy;
`ifdef IP_MATCH_COUNT_EN
  logic [1:0]   cnt_sel;
  logic [15:0]  cnt_val;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  ip_match_ctrl_if #(.NUM_IP(NumIp)) bus ();

  ip_match_ctrl #(
    .NUM_IP       (NumIp),
    .DRAIN_CYCLES (3)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .cfg_wr_en (cfg_wr_en),
    .cfg_sel   (cfg_sel),
    .cfg_ip    (cfg_ip),
    .cfg_en    (cfg_en),
    .cfg_err   (cfg_err),
    .cmp_clear (cmp_clear),
    .cmp_ip    (cmp_ip),
    .cmp_data  (cmp_data),
    .cmp_match (cmp_match),
`ifdef IP_MATCH_COUNT_EN
    .cnt_sel   (cnt_sel),
    .cnt_val   (cnt_val),
`endif
    .busy      (busy),
    .bus       (bus.slave)
  );

  always #5 clk = ~clk;

  // Comparator lanes: a target may straddle two consecutive words.
  function automatic logic [3:0] lane_hits(input logic [31:0] p, input logic [31:0] c,
                                           input logic [127:0] ips);
    logic [63:0] win;
    logic [3:0]  r;
    win = {p, c};
    r   = '0;
    for (int l = 0; l < 4; l++) begin
      for (int k = 0; k <= 4; k++) begin
        if (win[63-8*k -: 32] == ips[32*l +: 32]) r[l] = 1'b1;
      end
    end
    return r;
  endfunction

  logic [31:0] prev_w;
  logic [3:0]  match_q;
  assign cmp_match = match_q;

  always @(posedge clk) begin
    if (!n_rst || cmp_clear) begin
      prev_w  <= '0;
      match_q <= '0;
    end else begin
      prev_w  <= cmp_data;
      match_q <= match_q | lane_hits(prev_w, cmp_data, cmp_ip);
    end
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] sel, input logic [31:0] ip, input logic en);
    cfg_wr_en = 1'b1;
    cfg_sel   = sel;
    cfg_ip    = ip;
    cfg_en    = en;
    step();
    cfg_wr_en = 1'b0;
  endtask

  task automatic start_pkt();
    bus.pkt_start = 1'b1;
    step();
    check_eq("clear_pulse", cmp_clear, 1'b1);
    check_eq("clear_not_ready", bus.pkt_ready, 1'b0);
    bus.pkt_start = 1'b0;
    step();
  endtask

  task automatic send_word(input logic [31:0] w, input logic last);
    bus.pkt_valid = 1'b1;
    bus.pkt_data  = w;
    bus.pkt_end   = last;
    step();
    bus.pkt_valid = 1'b0;
    bus.pkt_end   = 1'b0;
  endtask

  task automatic wait_result(input string tag, input int exp_lat);
    int n;
    n = 0;
    while (!bus.res_valid && n < 20) begin
      step();
      n++;
    end
    check_eq({tag, "_valid"}, bus.res_valid, 1'b1);
    check_eq({tag, "_latency"}, n, exp_lat);
  endtask

  task automatic accept_result();
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    check_eq("res_released", bus.res_valid, 1'b0);
  endtask

  initial begin
    n_rst = 1'b0;
    cfg_wr_en = 1'b0; cfg_sel = '0; cfg_ip = '0; cfg_en = 1'b0;
    bus.pkt_start = 1'b0; bus.pkt_valid = 1'b0; bus.pkt_data = '0; bus.pkt_end = 1'b0;
    bus.res_ready = 1'b0;
`ifdef IP_MATCH_COUNT_EN
    cnt_sel = '0;
`endif
    step();
    step();
    check_eq("rst_ready", bus.pkt_ready, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_res_valid", bus.res_valid, 1'b0);
    check_eq("rst_cmp_ip", cmp_ip, 128'h0);
    check_eq("rst_cfg_err", cfg_err, 1'b0);
    n_rst = 1'b1;
    step();
    check_eq("idle_ready", bus.pkt_ready, 1'b1);

    // Lane 0 target split across two words.
    cfg_write(2'd0, 32'hC0A80001, 1'b1);
    check_eq("cfg_lane0", cmp_ip[31:0], 32'hC0A80001);
    check_eq("cfg_idle_no_err", cfg_err, 1'b0);
    start_pkt();
    check_eq("stream_busy", busy, 1'b1);
    check_eq("stream_ready", bus.pkt_ready, 1'b1);
    send_word(32'h00C0A800, 1'b0);
    check_eq("cmp_data_word", cmp_data, 32'h00C0A800);
    send_word(32'h01123456, 1'b1);
    check_eq("drain_not_ready", bus.pkt_ready, 1'b0);
    wait_result("p1", 3);
    check_eq("p1_hit", bus.res_hit, 1'b1);
    check_eq("p1_idx", bus.res_idx, 2'd0);
    check_eq("p1_mask", bus.res_mask, 4'b0001);
    check_eq("p1_err", bus.res_err, 1'b0);
    accept_result();

    // Two enabled lanes match; result held while res_ready stays low.
    cfg_write(2'd1, 32'h11223344, 1'b1);
    cfg_write(2'd2, 32'h55667788, 1'b1);
    start_pkt();
    send_word(32'h11223344, 1'b0);
    send_word(32'h55667788, 1'b1);
    wait_result("p2", 3);
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("p2_hold_valid", bus.res_valid, 1'b1);
      check_eq("p2_hold_mask", bus.res_mask, 4'b0110);
      check_eq("p2_hold_idx", bus.res_idx, 2'd1);
    end
    accept_result();

    // Disabled lane still drives its target but is masked out; single-word packet.
    cfg_write(2'd3, 32'hDEADBEEF, 1'b0);
    check_eq("disabled_drives_ip", cmp_ip[127:96], 32'hDEADBEEF);
    start_pkt();
    send_word(32'hDEADBEEF, 1'b1);
    wait_result("p3", 3);
    check_eq("p3_hit", bus.res_hit, 1'b0);
    check_eq("p3_mask", bus.res_mask, 4'b0000);
    accept_result();

    // Bubble after two words: error result with match data suppressed.
    start_pkt();
    send_word(32'hC0A80001, 1'b0);
    send_word(32'h12345678, 1'b0);
    wait_result("p4", 4);
    check_eq("p4_err", bus.res_err, 1'b1);
    check_eq("p4_hit", bus.res_hit, 1'b0);
    check_eq("p4_mask", bus.res_mask, 4'b0000);
    accept_result();

    // Restart mid-stream: clear pulse, no result for the aborted packet.
    start_pkt();
    send_word(32'hC0A80001, 1'b0);
    bus.pkt_start = 1'b1;
    step();
    bus.pkt_start = 1'b0;
    check_eq("abort_clear", cmp_clear, 1'b1);
    check_eq("abort_no_res", bus.res_valid, 1'b0);
    step();
    check_eq("abort_stream_no_res", bus.res_valid, 1'b0);
    send_word(32'h55667788, 1'b1);
    wait_result("p5", 3);
    check_eq("p5_mask", bus.res_mask, 4'b0100);
    check_eq("p5_idx", bus.res_idx, 2'd2);
    check_eq("p5_err", bus.res_err, 1'b0);
    accept_result();

    // Config write outside IDLE is dropped; then reset lands in DRAIN.
    start_pkt();
    cfg_wr_en = 1'b1; cfg_sel = 2'd0; cfg_ip = 32'hFFFFFFFF; cfg_en = 1'b0;
    send_word(32'hAAAAAAAA, 1'b0);
    cfg_wr_en = 1'b0;
    check_eq("stream_cfg_err", cfg_err, 1'b1);
    check_eq("stream_cfg_ip_kept", cmp_ip[31:0], 32'hC0A80001);
    send_word(32'hBBBBBBBB, 1'b1);
    check_eq("cfg_err_one_cycle", cfg_err, 1'b0);
    n_rst = 1'b0;
    step();
    check_eq("drain_rst_busy", busy, 1'b0);
    check_eq("drain_rst_valid", bus.res_valid, 1'b0);
    check_eq("drain_rst_ready", bus.pkt_ready, 1'b0);
    check_eq("drain_rst_cmp_ip", cmp_ip, 128'h0);
    check_eq("drain_rst_cmp_data", cmp_data, 32'h0);
    n_rst = 1'b1;
    step();
    check_eq("post_rst_ready", bus.pkt_ready, 1'b1);
    for (int i = 0; i < 4; i++) step();
    check_eq("post_rst_no_res", bus.res_valid, 1'b0);

`ifdef IP_MATCH_COUNT_EN
    cfg_write(2'd3, 32'hDEADBEEF, 1'b1);
    cnt_sel = 2'd3;
    #1;
    check_eq("cnt_start", cnt_val, 16'd0);
    for (int p = 0; p < 3; p++) begin
      start_pkt();
      send_word(32'hDEADBEEF, 1'b1);
      wait_result("cnt_pkt", 3);
      check_eq("cnt_pkt_mask", bus.res_mask, 4'b1000);
      accept_result();
    end
    check_eq("cnt_three", cnt_val, 16'd3);
    dut.hit_cnt_q[3] = 16'hFFFE;
    for (int p = 0; p < 2; p++) begin
      start_pkt();
      send_word(32'hDEADBEEF, 1'b1);
      wait_result("sat_pkt", 3);
      accept_result();
    end
    check_eq("cnt_saturate", cnt_val, 16'hFFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
